// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - PLL supervisor state encoding and counter width helper
package pll_sup_pkg;

  typedef enum logic [1:0] {
    S_PLLRST    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } pll_state_e;

  // Width that holds every terminal count (max-1) of the shared counter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// rtl/pll_sup_sync.sv - multi-flop synchronizer for the asynchronous pll_locked input
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset and system reset around PLL lock
// Optional saturating lock-loss counter port loss_cnt under `LOCK_LOSS_CNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT   = 50000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state_o
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  logic          lock_s;
  pll_state_e    state_q;
  logic [CW-1:0] cnt_q;

  pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // cnt is cleared on every transition so each state counts from zero.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_PLLRST;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_PLLRST: begin
          if (cnt_q == PLLRST_LAST) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q <= S_PLLRST;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign pll_rst = (state_q == S_PLLRST);
  assign sys_rst = (state_q != S_RUN);
  assign ready   = (state_q == S_RUN);
  assign state_o = state_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk) begin
    if (rst)
      loss_q <= '0;
    else if (state_q == S_RUN && !lock_s && loss_q != 8'hFF)
      loss_q <= loss_q + 8'd1;
  end

  assign loss_cnt = loss_q;
`endif

endmodule
